// File: rtl/fifo_chk_pkg.sv
// fifo_chk_pkg: shared types and helpers for the FIFO protocol checker
package fifo_chk_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, PUSH_FULL = 2'd1, POP_EMPTY = 2'd2, MISMATCH = 2'd3} err_code_e;
    typedef struct packed {
        logic push_full;
        logic pop_empty;
        logic mismatch;
    } chan_err_t;
    function automatic int chan_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_protocol_checker_if.sv
// fifo_protocol_checker_if: per-channel FIFO strobes and flags seen by the checker
interface fifo_protocol_checker_if #(parameter int NCH = 4);
    logic [NCH-1:0] push, pop, full, empty;
    modport master(output push, pop, full, empty);
    modport slave(input push, pop, full, empty);
endinterface

// File: rtl/fifo_chk_chan.sv
// fifo_chk_chan: shadow occupancy of one FIFO and its per-cycle violation bits
module fifo_chk_chan
    import fifo_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter bit ALLOW_PP_FULL = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      full,
    input  logic      empty,
    output chan_err_t err
);
    localparam int OW = $clog2(DEPTH + 1);
    logic [OW-1:0] occ;
    logic is_full, is_empty, push_ok, pop_ok;
    assign is_full  = occ == OW'(DEPTH);
    assign is_empty = occ == '0;
    assign push_ok  = push && (!is_full || (ALLOW_PP_FULL && pop));
    assign pop_ok   = pop && !is_empty;
    // a same-cycle push never rescues a pop on empty: no fall-through
    assign err.push_full = push && !push_ok;
    assign err.pop_empty = pop && is_empty;
    assign err.mismatch  = (full != is_full) || (empty != is_empty);
    always_ff @(posedge clk or posedge rst)
        if (rst) occ <= '0;
        else occ <= occ + OW'(push_ok) - OW'(pop_ok);
endmodule

// File: rtl/fifo_protocol_checker.sv
// fifo_protocol_checker: arbitrated error reporting, sticky flags, first-error capture and counters
module fifo_protocol_checker
    import fifo_chk_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16,
    parameter bit ALLOW_PP_FULL = 1'b1,
    localparam int CW = chan_w(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_protocol_checker_if.slave bus,
    input  logic                 clr,
    output logic                 err_valid,
    output logic [CW-1:0]        err_chan,
    output logic [1:0]           err_code,
    output logic [NCH-1:0]       err_sticky,
    output logic                 first_valid,
    output logic [CW-1:0]        first_chan,
    output logic [1:0]           first_code,
    output logic [CNT_W-1:0]     push_full_cnt,
    output logic [CNT_W-1:0]     pop_empty_cnt,
    output logic [CNT_W-1:0]     mismatch_cnt
);
    logic [NCH-1:0] pf, pe, mm, viol;
    logic [CW-1:0] a_chan;
    err_code_e a_code;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        chan_err_t e;
        fifo_chk_chan #(.DEPTH(DEPTH), .ALLOW_PP_FULL(ALLOW_PP_FULL)) u_chan (
            .clk, .rst, .push(bus.push[c]), .pop(bus.pop[c]),
            .full(bus.full[c]), .empty(bus.empty[c]), .err(e)
        );
        assign pf[c] = e.push_full;
        assign pe[c] = e.pop_empty;
        assign mm[c] = e.mismatch;
    end
    assign viol = pf | pe | mm;
    // scan high to low so the lowest violating channel wins
    always_comb begin
        a_chan = '0;
        a_code = NONE;
        for (int i = NCH - 1; i >= 0; i--)
            if (viol[i]) begin
                a_chan = CW'(i);
                a_code = pf[i] ? PUSH_FULL : pe[i] ? POP_EMPTY : MISMATCH;
            end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            err_valid     <= 1'b0;
            err_chan      <= '0;
            err_code      <= '0;
            err_sticky    <= '0;
            first_valid   <= 1'b0;
            first_chan    <= '0;
            first_code    <= '0;
            push_full_cnt <= '0;
            pop_empty_cnt <= '0;
            mismatch_cnt  <= '0;
        end else begin
            err_valid <= |viol;
            err_chan  <= a_chan;
            err_code  <= a_code;
            if (clr) begin
                err_sticky    <= '0;
                first_valid   <= 1'b0;
                first_chan    <= '0;
                first_code    <= '0;
                push_full_cnt <= '0;
                pop_empty_cnt <= '0;
                mismatch_cnt  <= '0;
            end else begin
                err_sticky <= err_sticky | viol;
                if (!first_valid && |viol) begin
                    first_valid <= 1'b1;
                    first_chan  <= a_chan;
                    first_code  <= a_code;
                end
                push_full_cnt <= push_full_cnt + CNT_W'(|pf && !(&push_full_cnt));
                pop_empty_cnt <= pop_empty_cnt + CNT_W'(|pe && !(&pop_empty_cnt));
                mismatch_cnt  <= mismatch_cnt + CNT_W'(|mm && !(&mismatch_cnt));
            end
        end
endmodule
